sr_flag_sched: RTL
==================

Name: sr_flag_sched

Overview:
- Schedules set/clear requests from NREQ requesters onto one shared SR flag register (ffsr: s, r, q).
- Round-robin arbitration; drives s/r as a timed pulse, then a settle cycle, then a one-cycle ack.
- Guarantees s and r are never asserted together.
- Skips the pulse when the flag already holds the requested value, and flags a sticky fault if q fails to follow.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PULSE_CYC, 2, cycles s or r is held high per operation (>=1).
- CW, $clog2(PULSE_CYC+1), pulse counter width; derived, not overridden.
- IW, $clog2(NREQ), index width; derived.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous reset, active-high; clears all state immediately.
- req  in  NREQ  request per requester; held until its ack.
- op  in  NREQ  per-requester operation: 1 = set, 0 = clear; stable while req is high.
- q_in  in  1  current q of the SR flag register.
- s_out  out  1  set drive to the SR flag.
- r_out  out  1  reset drive to the SR flag.
- gnt  out  NREQ  one-hot grant, high from the grant edge through the ack cycle.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- fault  out  1  sticky: q_in did not match the op at settle.

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-pulse):
  - state = IDLE, s_out = r_out = 0, gnt = ack = 0, busy = 0, fault = 0.
  - Round-robin pointer ptr = 0.
  - Any operation in progress is dropped without ack.
- FSM states: IDLE, DRIVE, SETTLE, ACK.
- IDLE, at a clock edge with any req high:
  - Winner w = first set bit of req searching from ptr upward, wrapping at NREQ.
  - Latch w and op[w]; gnt <= onehot(w).
  - If op[w] == q_in: go to ACK (skip path; s/r stay 0).
  - Else: go to DRIVE with cnt = PULSE_CYC-1, s_out <= op[w], r_out <= ~op[w].
- IDLE with no req: remain in IDLE; all outputs 0.
- DRIVE:
  - Hold s_out/r_out.
  - If cnt == 0: go to SETTLE with s_out = r_out = 0. Else cnt <= cnt-1.
  - s/r are high for exactly PULSE_CYC cycles.
- SETTLE (1 cycle), at the exit edge:
  - If q_in != latched op, fault <= 1.
  - Go to ACK.
- ACK (1 cycle):
  - ack[w] = 1, gnt still = onehot(w).
  - At the exit edge: gnt <= 0, ptr <= (w+1) mod NREQ, go to IDLE.
- Latency, grant edge to ack high:
  - PULSE_CYC+1 cycles on the drive path.
  - 0 extra cycles on the skip path (ack in the cycle after the grant edge).
  - Drive-path occupancy: PULSE_CYC+2 cycles. Skip-path occupancy: 1 cycle.
- Handshake rules:
  - A requester deasserts req on the edge where it samples ack = 1.
  - Back-to-back grants are separated by at least one IDLE cycle.
  - req dropping mid-operation is ignored: the operation completes and ack is still issued.
  - op changes after the grant edge are ignored.
- Simultaneous requests: exactly one grant. Fairness: a continuously requesting agent waits at most NREQ-1 operations.
- Conflicting ops from different requesters are serialized in round-robin order; the final flag value is that of the last one acked.
- Invariants: never s_out & r_out. At most one gnt bit and one ack bit set.
- fault clears only on reset.

Decomposition:
- Shared package sr_sched_pkg:
  - State encoding localparams: IDLE = 2'd0, DRIVE = 2'd1, SETTLE = 2'd2, ACK = 2'd3.
  - OP_SET = 1'b1, OP_CLR = 1'b0.
- One sub-module: rr_pick (combinational round-robin first-one finder).
  - Inputs: req[NREQ], ptr[IW]. Outputs: idx[IW], valid.
  - Reused by later arbiters.
- FSM, counter and output registers live in sr_flag_sched.

Test Plan:
1. Reset mid-pulse: PULSE_CYC = 2, req = 4'b0001, op = 1, q_in = 0; assert rstn at the 1st DRIVE cycle -> s_out, gnt, busy = 0 immediately; no ack; ptr = 0.
2. Single set: q_in = 0, req = 4'b0010, op[1] = 1 -> gnt = 4'b0010 at edge E; s_out = 1 for cycles E..E+1; r_out = 0 throughout; ack = 4'b0010 in cycle E+3; fault = 0.
3. Skip path: q_in = 1, req = 4'b0100, op[2] = 1 -> s_out/r_out never high; ack = 4'b0100 one cycle after grant; busy high for 1 cycle.
4. Round-robin fairness: req = 4'b1111 held, each requester re-requests after its ack -> grant order 0, 1, 2, 3, 0; no requester is granted twice before all others are served.
5. Conflict serialization: req = 4'b0011, op[0] = 1, op[1] = 0, flag model follows s/r -> r0 sets (s pulse), r1 clears (r pulse); s_out & r_out never both 1; final q = 0.
6. Fault: q_in tied 0, set request -> fault = 1 after SETTLE; the ack is still issued; fault stays 1 through later ops until reset.

Source files
------------

// File: rtl/sr_sched_pkg.sv
// Shared definitions for the SR flag scheduler and its arbiter helpers.
// FSM state encoding and operation codes.
package sr_sched_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t DRIVE  = 2'd1;
   localparam state_t SETTLE = 2'd2;
   localparam state_t ACK    = 2'd3;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_flag_sched_rr_pick.sv
// Combinational round-robin first-one finder: returns the first set bit of req
// at or above ptr, wrapping at NREQ.
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   idx,
   output logic            valid
);

   // rot[k] is req[(ptr + k) mod NREQ]
   logic [NREQ-1:0] rot;

   always_comb begin
      rot   = NREQ'({req, req} >> ptr);
      idx   = '0;
      valid = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            idx   = IW'((int'(ptr) + k) % NREQ);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_flag_sched.sv
// Round-robin scheduler of set/clear requests onto one shared SR flag:
// timed s/r pulse, one settle cycle, one ack cycle, with a skip path when q already matches.
module sr_flag_sched
   import sr_sched_pkg::*;
#(
   parameter  int NREQ      = 4,
   parameter  int PULSE_CYC = 2,
   localparam int CW        = $clog2(PULSE_CYC + 1),
   localparam int IW        = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] op,
   input  logic            q_in,
   output logic            s_out,
   output logic            r_out,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] ack,
   output logic            busy,
   output logic            fault
);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   w_q, w_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic            op_q, op_d;
   logic            s_q, s_d, r_q, r_d;
   logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
   logic            busy_q, busy_d, fault_q, fault_d;

   logic [IW-1:0]   pick_idx;
   logic            pick_valid;

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         w_q     <= '0;
         ptr_q   <= '0;
         op_q    <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         gnt_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         ptr_q   <= ptr_d;
         op_q    <= op_d;
         s_q     <= s_d;
         r_q     <= r_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      op_d    = op_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               w_d  = pick_idx;
               op_d = op[pick_idx];
               if (op[pick_idx] == q_in) begin
                  state_d = ACK;
               end else begin
                  state_d = DRIVE;
                  cnt_d   = CW'(PULSE_CYC - 1);
               end
            end
         end
         DRIVE: begin
            if (cnt_q == '0) state_d = SETTLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         SETTLE: state_d = ACK;
         ACK: begin
            state_d = IDLE;
            ptr_d   = (w_q == IW'(NREQ - 1)) ? '0 : w_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // s and r are only ever loaded as complements, so they can never both be high
   always_comb begin
      s_d     = 1'b0;
      r_d     = 1'b0;
      gnt_d   = gnt_q;
      ack_d   = '0;
      busy_d  = (state_d != IDLE);
      fault_d = fault_q;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (pick_valid) begin
               gnt_d = onehot(pick_idx);
               if (op[pick_idx] != q_in) begin
                  s_d = (op[pick_idx] == OP_SET);
                  r_d = (op[pick_idx] == OP_CLR);
               end else begin
                  ack_d = onehot(pick_idx);
               end
            end
         end
         DRIVE: begin
            if (cnt_q != '0) begin
               s_d = s_q;
               r_d = r_q;
            end
         end
         SETTLE: begin
            if (q_in != op_q) fault_d = 1'b1;
            ack_d = onehot(w_q);
         end
         ACK: gnt_d = '0;
         default: ;
      endcase
   end

   assign s_out = s_q;
   assign r_out = r_q;
   assign gnt   = gnt_q;
   assign ack   = ack_q;
   assign busy  = busy_q;
   assign fault = fault_q;

endmodule
